// File: rtl/wdt_rst_req_if.sv
// Register-slave bus between the CPU I/O decoder and the watchdog.
// One-cycle strobe in, registered acknowledge and read data out.
interface wdt_rst_req_if;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;

    modport master (output stb, we, addr, din, input  dout, ack);
    modport slave  (input  stb, we, addr, din, output dout, ack);
endinterface

// File: rtl/wdt_rst_req.sv
// Watchdog that drives an active-low reset request pulse on timeout or on a bad kick key.
// Define WDT_WARN_EN to add the quarter-timeout early-warning interrupt.
module wdt_rst_req #(
    parameter int                   CNT_WIDTH   = 24,
    parameter int                   PULSE_LEN   = 16,
    parameter logic [7:0]           KICK_KEY    = 8'hA5,
    parameter logic [CNT_WIDTH-1:0] DEF_TIMEOUT = {CNT_WIDTH{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    wdt_rst_req_if.slave bus,
    output logic         rst_req_n,
    output logic         warn_irq
);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [1:0] A_CTRL = 2'd0, A_TIMEOUT = 2'd1, A_KICK = 2'd2, A_COUNT = 2'd3;

    typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

    state_t               state_q;
    logic                 en_q, lock_q, bad_q, rst_req_q, ack_q, cause_q;
    logic [CNT_WIDTH-1:0] count_q, timeout_q, timeout_d;
    logic [PW-1:0]        pulse_q;
    logic [31:0]          dout_q, rd_data;
    logic                 wr, wr_ctrl, wr_to, kick, kick_ok, en_d;
    logic                 unused_din;

    assign unused_din = ^bus.din[31:CNT_WIDTH];

    always_comb begin
        wr        = bus.stb && bus.we && (state_q != FIRE);
        wr_ctrl   = wr && (bus.addr == A_CTRL);
        wr_to     = wr && (bus.addr == A_TIMEOUT);
        kick      = wr && (bus.addr == A_KICK) && (state_q == ARMED);
        kick_ok   = kick && (bus.din[7:0] == KICK_KEY);
        // Once locked, software can still set en but never clear it.
        en_d      = wr_ctrl ? (bus.din[0] | (lock_q & en_q)) : en_q;
        timeout_d = (bus.din[CNT_WIDTH-1:0] == '0) ? CNT_WIDTH'(1) : bus.din[CNT_WIDTH-1:0];
        case (bus.addr)
            A_CTRL:    rd_data = {28'b0, cause_q, warn_irq, lock_q, en_q};
            A_TIMEOUT: rd_data = 32'(timeout_q);
            A_COUNT:   rd_data = 32'(count_q);
            default:   rd_data = '0;
        endcase
    end

`ifdef WDT_WARN_EN
    logic warn_q;
    assign warn_irq = warn_q;
`else
    assign warn_irq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            lock_q    <= 1'b0;
            bad_q     <= 1'b0;
            rst_req_q <= 1'b1;
            ack_q     <= 1'b0;
            dout_q    <= '0;
            count_q   <= DEF_TIMEOUT;
            timeout_q <= DEF_TIMEOUT;
            pulse_q   <= '0;
`ifdef WDT_WARN_EN
            warn_q    <= 1'b0;
`endif
        end else begin
            ack_q  <= bus.stb;
            dout_q <= (bus.stb && !bus.we) ? rd_data : '0;
            en_q   <= en_d;
            if (wr_ctrl) lock_q <= lock_q | bus.din[1];
            if (wr_to)   timeout_q <= timeout_d;
            case (state_q)
                IDLE: begin
                    if (en_d && !en_q) begin
                        count_q <= timeout_q;
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    // A valid kick in the expiry cycle still rescues the system.
                    if (bad_q || (count_q == '0 && !kick_ok)) begin
                        state_q   <= FIRE;
                        rst_req_q <= 1'b0;
                        pulse_q   <= PW'(PULSE_LEN - 1);
                        bad_q     <= 1'b0;
`ifdef WDT_WARN_EN
                        warn_q    <= 1'b0;
`endif
                    end else if (!en_d) begin
                        state_q <= IDLE;
`ifdef WDT_WARN_EN
                        warn_q  <= 1'b0;
`endif
                    end else if (kick_ok) begin
                        count_q <= timeout_q;
`ifdef WDT_WARN_EN
                        warn_q  <= 1'b0;
`endif
                    end else begin
                        count_q <= count_q - CNT_WIDTH'(1);
                        bad_q   <= kick;
`ifdef WDT_WARN_EN
                        if (count_q - CNT_WIDTH'(1) == (timeout_q >> 2)) warn_q <= 1'b1;
`endif
                    end
                end
                FIRE: begin
                    if (pulse_q == '0) begin
                        state_q   <= IDLE;
                        rst_req_q <= 1'b1;
                        en_q      <= 1'b0;
                    end else begin
                        pulse_q <= pulse_q - PW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset cause must survive the system reset it provoked, so it sits outside rst.
    always_ff @(posedge clk) begin
        if (state_q == FIRE)             cause_q <= 1'b1;
        else if (wr_ctrl && bus.din[2])  cause_q <= 1'b0;
    end

    assign bus.dout  = dout_q;
    assign bus.ack   = ack_q;
    assign rst_req_n = rst_req_q;
endmodule
